// File: rtl/adder_accumulator.sv
// adder_accumulator: sums a run of len_i adder result words (with carry-out) into a registered accumulator with sticky overflow
module adder_accumulator #(
  parameter int DATASIZE = 8,
  parameter int ACCSIZE  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [7:0]          len_i,
  input  logic [DATASIZE-1:0] result_i,
  input  logic                carry_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [ACCSIZE-1:0]  sum_o,
  output logic                overflow_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t               r_state;
  logic [7:0]           r_cnt;
  logic [ACCSIZE-1:0]   r_sum;
  logic                 r_ovf;
  logic                 r_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic [ACCSIZE:0]     w_sum;
  assign w_sum = {1'b0, r_sum} + {{(ACCSIZE-DATASIZE){1'b0}}, carry_i, result_i};
  assign ready_o     = r_ready;
  assign sum_o       = r_sum;
  assign overflow_o  = r_ovf;
  assign out_valid_o = r_out_valid;
  assign busy_o      = r_busy;
  // run control FSM; handshake outputs are registered alongside the state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_ready     <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start_i) begin
          r_cnt       <= len_i;
          r_sum       <= '0;
          r_ovf       <= 1'b0;
          r_busy      <= 1'b1;
          r_state     <= (len_i == 8'd0) ? DONE : ACCUM;
          r_ready     <= (len_i != 8'd0);
          r_out_valid <= (len_i == 8'd0);
        end
        ACCUM: if (valid_i) begin
          r_sum <= w_sum[ACCSIZE-1:0];
          r_ovf <= r_ovf | w_sum[ACCSIZE];
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            r_state     <= DONE;
            r_ready     <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready_i) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_accumulator.sv
// tb_adder_accumulator: table-driven runs with a result scoreboard plus reset corner sequences
module tb_adder_accumulator;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  len_i = '0;
  logic [7:0]  result_i = '0;
  logic        carry_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [15:0] sum_o;
  logic        overflow_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic        busy_o;

  adder_accumulator #(.DATASIZE(8), .ACCSIZE(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
    .result_i(result_i), .carry_i(carry_i), .valid_i(valid_i),
    .ready_o(ready_o), .sum_o(sum_o), .overflow_o(overflow_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int len; int base; int step; int carry; int gap; int hold; int poke;
    int sum; int ovf;
  } vec_t;
  typedef struct { logic [15:0] sum; logic ovf; } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic run(input vec_t v);
    exp_t e;
    exp_t got;
    chk("idle_ready", ready_o, 0);
    chk("idle_out_valid", out_valid_o, 0);
    start_i = 1'b1;
    len_i = v.len[7:0];
    e.sum = v.sum[15:0];
    e.ovf = v.ovf[0];
    sb.push_back(e);
    tick;
    start_i = 1'b0;
    len_i = 8'hAA;
    chk("busy_after_start", busy_o, 1);
    for (int i = 0; i < v.len; i++) begin
      for (int g = 0; g < v.gap; g++) begin
        valid_i = 1'b0;
        result_i = 8'hFF;
        carry_i = 1'b1;
        tick;
      end
      if (i == 0 || i == v.len - 1) chk("accum_ready", ready_o, 1);
      result_i = 8'(v.base + i * v.step);
      carry_i = v.carry[0];
      valid_i = 1'b1;
      if (v.poke != 0 && i == 0) begin
        start_i = 1'b1;
        len_i = 8'd1;
      end
      tick;
      start_i = 1'b0;
      valid_i = 1'b0;
    end
    chk("out_valid_latency", out_valid_o, 1);
    chk("done_ready_low", ready_o, 0);
    chk("done_busy", busy_o, 1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      got = sb.pop_front();
      chk("sum", sum_o, got.sum);
      chk("overflow", overflow_o, got.ovf);
    end
    for (int h = 0; h < v.hold; h++) begin
      tick;
      chk("hold_valid", out_valid_o, 1);
      chk("hold_sum", sum_o, e.sum);
      chk("hold_ovf", overflow_o, e.ovf);
    end
    out_ready_i = 1'b1;
    if (v.poke != 0) begin
      start_i = 1'b1;
      len_i = 8'd3;
    end
    tick;
    out_ready_i = 1'b0;
    start_i = 1'b0;
    chk("idle_after_ack_valid", out_valid_o, 0);
    chk("idle_after_ack_busy", busy_o, 0);
    tick;
    chk("start_ignored_busy", busy_o, 0);
    chk("idle_sum_held", sum_o, e.sum);
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{4,   10,  10, 0, 0, 0, 0, 100,   0};
    vt[1] = '{0,   0,   0,  0, 0, 0, 0, 0,     0};
    vt[2] = '{200, 255, 0,  1, 0, 0, 0, 36664, 1};
    vt[3] = '{3,   5,   1,  0, 2, 5, 0, 18,    0};
    vt[4] = '{4,   1,   1,  0, 0, 1, 1, 10,    0};
    vt[5] = '{128, 255, 0,  1, 0, 0, 0, 65408, 0};
    vt[6] = '{129, 255, 0,  1, 0, 0, 0, 383,   1};
    vt[7] = '{255, 0,   1,  0, 0, 0, 0, 32385, 0};
    vt[8] = '{1,   0,   0,  1, 1, 2, 1, 256,   0};

    tick;
    tick;
    chk("rst_sum", sum_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_ni = 1'b1;
    tick;

    for (int k = 0; k < 9; k++) run(vt[k]);

    start_i = 1'b1;
    len_i = 8'd5;
    tick;
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      result_i = 8'd50;
      carry_i = 1'b0;
      valid_i = 1'b1;
      tick;
    end
    chk("midrun_sum", sum_o, 100);
    rst_ni = 1'b0;
    tick;
    rst_ni = 1'b1;
    chk("midrst_sum", sum_o, 0);
    chk("midrst_ovf", overflow_o, 0);
    chk("midrst_out_valid", out_valid_o, 0);
    chk("midrst_ready", ready_o, 0);
    chk("midrst_busy", busy_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("no_valid_after_rst", out_valid_o, 0);
      chk("idle_ignores_beats", sum_o, 0);
    end
    valid_i = 1'b0;
    run('{1, 7, 0, 0, 0, 0, 0, 7, 0});

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/adder_accumulator.md
ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 The block SHALL have parameter DATASIZE, default 8, width of the adder result word it consumes.
REQ-002 The block SHALL have parameter ACCSIZE, default 16, accumulator width; legal only if ACCSIZE >= DATASIZE+1.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: clk_i, rst_ni.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  synchronous active-low reset.
REQ-006 start_i  in  1  request a new accumulation run; sampled only in IDLE.
REQ-007 len_i  in  8  number of samples in the run; sampled with start_i.
REQ-008 result_i  in  DATASIZE  adder result word.
REQ-009 carry_i  in  1  adder carry-out belonging to result_i.
REQ-010 valid_i  in  1  result_i/carry_i valid.
REQ-011 ready_o  out  1  block accepts a sample this cycle.
REQ-012 sum_o  out  ACCSIZE  registered accumulated sum.
REQ-013 overflow_o  out  1  sticky: the accumulator wrapped during the run.
REQ-014 out_valid_o  out  1  sum_o/overflow_o final and valid.
REQ-015 out_ready_i  in  1  consumer accepts the result.
REQ-016 busy_o  out  1  high in ACCUM and DONE.

Function
REQ-017 States SHALL be IDLE, ACCUM, DONE; all outputs registered or decoded from state only.
REQ-018 IDLE: ready_o=0, out_valid_o=0; on start_i=1 with len_i=0 -> DONE, sum 0, overflow 0.
REQ-019 IDLE: on start_i=1 with len_i>0 -> ACCUM; counter=len_i, accumulator=0, overflow=0 in the same edge.
REQ-020 ACCUM: ready_o=1; a beat is accepted on a rising edge with valid_i=1 and ready_o=1.
REQ-021 Accepted beat: addend = {carry_i, result_i} zero-extended to ACCSIZE; accumulator = (accumulator + addend) mod 2^ACCSIZE.
REQ-022 Carry out of bit ACCSIZE-1 in any accepted addition SHALL set overflow; overflow never clears until the next run start or reset.
REQ-023 valid_i=0 cycles in ACCUM SHALL leave accumulator, counter and overflow unchanged.
REQ-024 Accepted beat with counter=1 -> DONE; out_valid_o=1 the cycle right after that edge (latency 1); ready_o=0 in that cycle.
REQ-025 DONE: sum_o, overflow_o stable while out_valid_o=1 and out_ready_i=0.
REQ-026 DONE with out_ready_i=1 -> IDLE next edge; start_i in that same cycle SHALL be ignored.
REQ-027 start_i in ACCUM or DONE SHALL be ignored; len_i changes outside IDLE have no effect.
REQ-028 sum_o SHALL hold its last value in IDLE until a new run starts.

Reset
REQ-029 rst_ni=0 on a rising edge SHALL force IDLE, sum_o=0, overflow_o=0, out_valid_o=0, ready_o=0, busy_o=0, counter=0.
REQ-030 Reset mid-run (ACCUM or DONE) SHALL discard the run; no out_valid_o pulse follows.

Verification (DATASIZE=8, ACCSIZE=16)
REQ-031 start, len=4; beats (10,0),(20,0),(30,0),(40,0) back-to-back -> out_valid_o 1 cycle after 4th beat, sum_o=100, overflow_o=0.
REQ-032 start, len=0 -> out_valid_o next cycle, sum_o=0, overflow_o=0, no beat accepted.
REQ-033 start, len=200; each beat (255,1)=511 -> sum_o=36664 (102200 mod 65536), overflow_o=1.
REQ-034 len=3, valid_i gaps between beats 5,6,7 and out_ready_i low 5 cycles -> sum_o=18 held stable throughout; IDLE one edge after out_ready_i=1.
REQ-035 len=5, reset after 2 beats -> all outputs 0, no out_valid_o; then len=1, beat (7,0) -> sum_o=7.
REQ-036 start_i pulsed in ACCUM and in the DONE/out_ready_i cycle -> ignored; counter and sum unaffected, block returns to IDLE.
